// File: rtl/adder_req_arbiter.sv
// Round-robin arbiter sharing one adder between NUM_REQ requesters.
// In-flight requester IDs ride an in-order tag FIFO back to the response.
module adder_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int MAX_OUT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]     req_a,
    input  logic [NUM_REQ*WIDTH-1:0]     req_b,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         add_valid,
    output logic [WIDTH-1:0]             add_a,
    output logic [WIDTH-1:0]             add_b,
    input  logic                         add_done,
    input  logic [WIDTH-1:0]             add_sum,
    input  logic                         add_cout,
    output logic                         rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [WIDTH:0]               rsp_sum,
    output logic [$clog2(MAX_OUT):0]     outstanding,
    output logic                         busy,
    output logic                         err_underflow
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = $clog2(MAX_OUT);
    localparam int CW  = PW + 1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    wr_q, rd_q;
    logic [IDW-1:0]   tag_mem [MAX_OUT];
    logic             add_valid_q;
    logic [WIDTH-1:0] add_a_q, add_b_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH:0]   rsp_sum_q;
    logic             err_q;

    logic             can_issue, found, hs, push, pop, under;
    logic [IDW-1:0]   gnt_id, idx;
    int               j;

    // A result returning this cycle frees its slot for a same-cycle issue.
    assign can_issue = (cnt_q < CW'(MAX_OUT)) || (add_done && cnt_q != '0);

    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        idx    = '0;
        j      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            idx = IDW'(j);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
    end

    assign hs        = can_issue && found && !rst;
    assign req_ready = hs ? (ONE << gnt_id) : '0;
    assign push      = hs;
    assign pop       = add_done && (cnt_q != '0);
    assign under     = add_done && (cnt_q == '0);

    always_comb begin
        ptr_d = ptr_q;
        if (hs) ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_q] <= gnt_id;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            cnt_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            add_valid_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            add_valid_q <= hs;
            rsp_valid_q <= pop;
            if (hs) begin
                add_a_q <= req_a[gnt_id*WIDTH +: WIDTH];
                add_b_q <= req_b[gnt_id*WIDTH +: WIDTH];
                wr_q    <= wr_q + 1'b1;
            end
            if (pop) begin
                rsp_id_q  <= tag_mem[rd_q];
                rsp_sum_q <= {add_cout, add_sum};
                rd_q      <= rd_q + 1'b1;
            end
            if (under) err_q <= 1'b1;
        end
    end

    assign add_valid     = add_valid_q;
    assign add_a         = add_a_q;
    assign add_b         = add_b_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_sum       = rsp_sum_q;
    assign outstanding   = cnt_q;
    assign busy          = (cnt_q != '0) || add_valid_q;
    assign err_underflow = err_q;
endmodule

// File: tb/tb_adder_req_arbiter.sv
// Scoreboard bench for adder_req_arbiter against a queue-based model.
// Driver works on falling edges; monitor pops expectations after rising edges.
module tb_adder_req_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int M = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic           add_valid;
    logic [W-1:0]   add_a, add_b;
    logic           add_done = 1'b0;
    logic [W-1:0]   add_sum = '0;
    logic           add_cout = 1'b0;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [W:0]     rsp_sum;
    logic [2:0]     outstanding;
    logic           busy;
    logic           err_underflow;

    adder_req_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_OUT(M)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .add_valid(add_valid), .add_a(add_a), .add_b(add_b),
        .add_done(add_done), .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .outstanding(outstanding), .busy(busy),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_iss[$];
    logic [10:0] exp_rsp[$];

    // Model state: next-preferred requester, tags and operands in flight.
    int          m_rr = 0;
    int          m_cnt = 0;
    bit          m_err = 1'b0;
    bit          m_addv = 1'b0;
    int          tagq[$];
    logic [15:0] opq[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pick();
        int r;
        r = $urandom_range(0, 5);
        case (r)
            0: return 8'hFF;
            1: return 8'h80;
            2: return 8'h01;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (add_valid) begin
                if (exp_iss.size() == 0) chk("add_unexp", 1, 0);
                else chk("add_ops", {add_a, add_b}, exp_iss.pop_front());
            end
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) chk("rsp_unexp", 1, 0);
                else chk("rsp", {rsp_id, rsp_sum}, exp_rsp.pop_front());
            end
        end
    end

    // One cycle, entered and left at a falling edge.
    task automatic cycle(input logic [N-1:0] rv, input bit done);
        logic [N-1:0] eg;
        logic [15:0]  h;
        logic [8:0]   s;
        bit           ci;
        int           g;
        chk("outstanding", int'(outstanding), m_cnt);
        chk("err_underflow", int'(err_underflow), int'(m_err));
        chk("busy", int'(busy), int'(m_cnt != 0 || m_addv));
        req_valid = rv;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = pick();
            req_b[i*W +: W] = pick();
        end
        add_done = done;
        if (done && opq.size() != 0) begin
            h = opq[0];
            s = 9'(h[15:8]) + 9'(h[7:0]);
            {add_cout, add_sum} = s;
        end else begin
            add_sum  = 8'($urandom);
            add_cout = 1'($urandom);
        end
        #1;
        ci = (m_cnt < M) || (done && m_cnt != 0);
        g  = -1;
        if (ci) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && rv[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("req_ready", int'(req_ready), int'(eg));
        if (done) begin
            if (m_cnt != 0) begin
                void'(opq.pop_front());
                exp_rsp.push_back({2'(tagq.pop_front()), add_cout, add_sum});
                m_cnt--;
            end else begin
                m_err = 1'b1;
            end
        end
        m_addv = (g >= 0);
        if (g >= 0) begin
            h = {req_a[g*W +: W], req_b[g*W +: W]};
            tagq.push_back(g);
            opq.push_back(h);
            exp_iss.push_back(h);
            m_rr = (g + 1) % N;
            m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        add_done  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        m_rr   = 0;
        m_cnt  = 0;
        m_err  = 1'b0;
        m_addv = 1'b0;
        tagq.delete();
        opq.delete();
    endtask

    task automatic drain();
        while (m_cnt != 0) cycle('0, 1'b1);
        cycle('0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        chk("rst_add_valid", int'(add_valid), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_add_a", int'(add_a), 0);
        chk("rst_rsp_sum", int'(rsp_sum), 0);

        // Single request, result three cycles after issue.
        cycle(4'b0010, 1'b0);
        repeat (3) cycle('0, 1'b0);
        cycle('0, 1'b1);
        cycle('0, 1'b0);

        // Round robin to full credit, then a same-cycle pop and issue.
        repeat (5) cycle(4'hF, 1'b0);
        cycle(4'hF, 1'b1);
        cycle(4'hF, 1'b0);
        drain();

        // Steady push/pop stream.
        cycle(4'b0100, 1'b0);
        for (int i = 0; i < 20; i++) cycle(4'b1 << (i % N), 1'b1);
        drain();

        // Random traffic with varying return rates.
        for (int i = 0; i < 600; i++) begin
            int p;
            p = (i < 200) ? 4 : (i < 400) ? 2 : 1;
            cycle(4'($urandom), (m_cnt != 0) && ($urandom_range(0, p - 1) == 0));
        end
        drain();

        // Underflow after reset is sticky and silent.
        do_reset();
        cycle('0, 1'b1);
        repeat (3) cycle('0, 1'b0);
        cycle(4'b0001, 1'b0);
        drain();

        // Reset with operations in flight.
        cycle(4'b1000, 1'b0);
        cycle(4'hF, 1'b0);
        cycle(4'hF, 1'b0);
        do_reset();
        cycle('0, 1'b1);
        cycle(4'hF, 1'b0);
        drain();

        repeat (3) cycle('0, 1'b0);
        chk("iss_left", exp_iss.size(), 0);
        chk("rsp_left", exp_rsp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder_req_arbiter.md
Name: adder_req_arbiter

Overview:
- Shares one external adder datapath between NUM_REQ requesters using round-robin arbitration.
- Issues granted operand pairs to the adder and tags each issued operation with its requester ID.
- Tracks in-flight operations with an in-order tag FIFO and routes each adder result back with its originating ID.
- Sits between requester agents (driver side) and the adder, whose results are checked by the monitor side.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width in bits.
- MAX_OUT, 4, maximum in-flight operations; power of two, 2..16.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*WIDTH  packed operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed operand B; same packing as req_a.
- req_ready  out  NUM_REQ  one-hot grant; a handshake occurs when req_valid[i] && req_ready[i].
- add_valid  out  1  operation issued to the adder (registered).
- add_a  out  WIDTH  operand A to the adder (registered).
- add_b  out  WIDTH  operand B to the adder (registered).
- add_done  in  1  adder result valid; results return in issue order.
- add_sum  in  WIDTH  adder sum.
- add_cout  in  1  adder carry out.
- rsp_valid  out  1  response valid (registered).
- rsp_id  out  clog2(NUM_REQ)  requester ID of the response.
- rsp_sum  out  WIDTH+1  {add_cout, add_sum}.
- outstanding  out  clog2(MAX_OUT)+1  in-flight operation count.
- busy  out  1  high when outstanding != 0 or add_valid is high.
- err_underflow  out  1  sticky; set when add_done arrives with no operation outstanding.

Behaviour:
- Reset values:
  - All outputs are 0.
  - Round-robin pointer = 0.
  - Tag FIFO is empty; outstanding = 0.
  - err_underflow is cleared only by rst.
- Credit:
  - can_issue = (outstanding < MAX_OUT) || (add_done && outstanding != 0).
  - A pop in the same cycle frees a slot, so issue at full is allowed when a result returns that cycle.
- Arbitration (combinational):
  - When can_issue is high, grant the first i with req_valid[i] set, searching from the pointer upward with wrap (pointer, pointer+1, ..., NUM_REQ-1, 0, ...).
  - req_ready is one-hot or all-zero.
  - When can_issue is low, req_ready = 0.
  - req_ready never depends on add_done except through can_issue.
- Round-robin pointer:
  - On a handshake with requester g, pointer <= (g+1) mod NUM_REQ.
  - With no handshake, the pointer holds.
- Issue:
  - On a handshake, the next cycle has add_valid=1, add_a/add_b = the granted operands, and g is pushed into the tag FIFO.
  - With no handshake, add_valid=0 next cycle; add_a/add_b hold their previous values.
  - Maximum throughput is one issue per cycle.
- Outstanding counter:
  - +1 on push, -1 on valid pop.
  - Push and pop in the same cycle leave it unchanged.
  - It never exceeds MAX_OUT.
- Response:
  - Applies to add_done when outstanding != 0 (or a push that cycle does not matter: the FIFO head is used).
  - In the next cycle: rsp_valid=1, rsp_id = FIFO head, rsp_sum = {add_cout, add_sum}; the FIFO pops.
  - Latency from add_done to rsp_valid is exactly 1 cycle.
  - There is no response backpressure.
- Underflow:
  - Occurs when add_done=1 and the FIFO is empty.
  - No pop, no rsp_valid, err_underflow <= 1, and the counter does not change.
- FIFO wrap:
  - Read and write pointers are clog2(MAX_OUT) bits and wrap modulo MAX_OUT.
  - Full/empty are derived from outstanding.
- Reset mid-operation:
  - In-flight tags are discarded; no rsp is produced for them.
  - Any add_done in the first cycle after reset flags underflow.
- Operand arithmetic:
  - The block performs no arithmetic on data.
  - rsp_sum is a pure concatenation.

Test Plan:
1. Single request: req_valid=4'b0010, a=8'h05, b=8'h03, then add_done with sum=8'h08 and cout=0, 3 cycles after add_valid -> add_valid one cycle after handshake with add_a=05, add_b=03; rsp_valid with rsp_id=1, rsp_sum=9'h008; outstanding returns 0.
2. Round robin: all four req_valid held high, MAX_OUT=4, no add_done -> grants in order 0,1,2,3; then req_ready=0 with outstanding=4. Then add_done=1 -> same-cycle grant to 0 (pointer wrapped); outstanding stays 4.
3. Carry and order: issue IDs 2 then 0 with (FF,01) and (80,80); return sum=00, cout=1 twice -> rsp sequence is id=2 with 9'h100, then id=0 with 9'h100.
4. Simultaneous push/pop: steady state with one request and one add_done every cycle -> outstanding constant at 1; rsp_id tracks the issue order with no gaps.
5. Underflow: after reset, assert add_done=1 -> err_underflow=1 and stays high; rsp_valid=0; outstanding=0.
6. Reset mid-flight: issue 3 operations, assert rst for one cycle, then add_done -> no rsp_valid, err_underflow=1, pointer=0, and the next grant goes to requester 0.
